// File: rtl/game_pkg.sv
// Shared types and constants for the two-player turn scheduler.
//   state_t      : scheduler FSM states
//   P1 / P2      : activePlayer encodings
//   WIN_*        : winner output codes
//   decide_winner: maps final scores to a winner code
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    SWITCH = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  function automatic logic [1:0] decide_winner(input logic [7:0] s1, input logic [7:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_TIE;
  endfunction

endpackage

// File: rtl/game_turn_scheduler_turn_timer.sv
// turn_timer: one-second prescaler plus 8-bit seconds down-counter.
//   CLOCK_50 : clock (posedge)
//   reset    : synchronous active-high reset
//   load     : restart the turn (tick=0, secsLeft=TURN_SECS)
//   enable   : count this cycle (high while a turn is running)
//   secsLeft : seconds remaining in the turn
//   timeout  : strobe on the second tick that takes secsLeft from 1 to 0
module turn_timer #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned TURN_SECS     = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  output logic [7:0] secsLeft,
  output logic       timeout
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [TW-1:0] tick;
  logic          sec_tick;

  assign sec_tick = enable && (tick == TW'(TICKS_PER_SEC - 1));
  assign timeout  = sec_tick && (secsLeft == 8'd1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick     <= '0;
      secsLeft <= '0;
    end else if (load) begin
      tick     <= '0;
      secsLeft <= 8'(TURN_SECS);
    end else if (enable) begin
      tick <= sec_tick ? '0 : tick + TW'(1);
      if (sec_tick && secsLeft != '0)
        secsLeft <= secsLeft - 8'd1;
    end
  end

endmodule

// File: rtl/game_turn_scheduler.sv
// game_turn_scheduler: alternates timed turns between two players, keeps
// scores and rounds, pulses GameOver at the end of the last round.
//   CLOCK_50     : clock (posedge)
//   reset        : synchronous active-high reset
//   gamePlaying  : level, high while a game session is in progress
//   p_done[1:0]  : per-player early end-of-turn pulses
//   point        : credit one point to the active player
//   activePlayer : 0 = P1, 1 = P2
//   turnActive   : high while a turn is running
//   secsLeft     : seconds left in the current turn
//   round        : current round (0 after reset until the first start)
//   score1/2     : saturating player scores
//   GameOver     : one-cycle pulse at game end
//   winner       : 01 P1, 10 P2, 11 tie, 00 none
module game_turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned TURN_SECS     = 10,
  parameter int unsigned NUM_ROUNDS    = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       gamePlaying,
  input  logic [1:0] p_done,
  input  logic       point,
  output logic       activePlayer,
  output logic       turnActive,
  output logic [7:0] secsLeft,
  output logic [3:0] round,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic       GameOver,
  output logic [1:0] winner
);

  state_t state, state_n;
  logic   prev_playing;
  logic   start, turn_end, last_turn;
  logic   timer_load, timer_en, timeout;

  assign start      = gamePlaying & ~prev_playing;
  assign turn_end   = p_done[activePlayer] | timeout;
  assign last_turn  = (activePlayer == P2) && (round == 4'(NUM_ROUNDS));
  assign timer_en   = (state == TURN);
  assign turnActive = (state == TURN);
  assign GameOver   = (state == FINISH);

  turn_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .TURN_SECS    (TURN_SECS)
  ) u_timer (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .load    (timer_load),
    .enable  (timer_en),
    .secsLeft(secsLeft),
    .timeout (timeout)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    timer_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n    = TURN;
          timer_load = 1'b1;
        end
      end
      TURN: begin
        if (!gamePlaying)  state_n = IDLE;
        else if (turn_end) state_n = SWITCH;
      end
      SWITCH: begin
        if (!gamePlaying)   state_n = IDLE;
        else if (last_turn) state_n = FINISH;
        else begin
          state_n    = TURN;
          timer_load = 1'b1;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // Held high through reset so a session already in progress must drop
      // and rise again before a new game can start.
      prev_playing <= 1'b1;
      activePlayer <= P1;
      round        <= '0;
      score1       <= '0;
      score2       <= '0;
      winner       <= WIN_NONE;
    end else begin
      prev_playing <= gamePlaying;
      unique case (state)
        IDLE: begin
          if (start) begin
            activePlayer <= P1;
            round        <= 4'd1;
            score1       <= '0;
            score2       <= '0;
            winner       <= WIN_NONE;
          end
        end
        TURN: begin
          if (point) begin
            if (activePlayer == P1) begin
              if (score1 != '1) score1 <= score1 + 8'd1;
            end else begin
              if (score2 != '1) score2 <= score2 + 8'd1;
            end
          end
        end
        SWITCH: begin
          if (gamePlaying) begin
            // Scores are frozen in SWITCH, so the winner is resolved here and
            // is already valid on the GameOver cycle.
            if (last_turn) begin
              winner <= decide_winner(score1, score2);
            end else begin
              activePlayer <= ~activePlayer;
              if (activePlayer == P2) round <= round + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
